// File: rtl/ft601_bus_arb.sv
// Round-robin RX/TX scheduler for the FT601 245-synchronous FIFO bus, with bounded bursts per grant.
// Optional beat/burst statistics counters are enabled by defining FT601_BUS_ARB_STATS_EN.
module ft601_bus_arb #(
  parameter int unsigned MAX_BURST = 256,
  parameter int unsigned CNT_W     = 12
) (
  input  logic        ft_clk,
  input  logic        ft_reset,
`ifdef FT601_BUS_ARB_STATS_EN
  input  logic        stats_clear,
  output logic [31:0] rx_beats,
  output logic [31:0] tx_beats,
  output logic [31:0] rx_bursts,
  output logic [31:0] tx_bursts,
`endif
  input  logic        rx_enable,
  input  logic        tx_enable,
  input  logic        ft_rxf_n,
  input  logic        ft_txe_n,
  output logic        ft_oe_n,
  output logic        ft_rd_n,
  output logic        ft_wr_n,
  output logic        ft_data_oe,
  input  logic        rx_afull,
  output logic        rx_ce,
  input  logic        tx_valid,
  output logic        tx_pop,
  output logic        grant_rx,
  output logic        grant_tx,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RX_OE    = 3'd1,
    S_RX_BURST = 3'd2,
    S_TX_BURST = 3'd3,
    S_TURN     = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_last_tx;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_oe_n;
  logic               r_rd_n;
  logic               r_data_oe;
  logic               r_grant_rx;
  logic               r_grant_tx;
  logic               r_busy;

  logic               w_rx_req;
  logic               w_tx_req;
  logic               w_cnt_last;
  logic               w_beat;
  logic               w_rx_ce;
  logic               w_tx_pop;
  logic               w_wr_n;

  assign w_rx_req   = rx_enable & ~ft_rxf_n & ~rx_afull;
  assign w_tx_req   = tx_enable & ~ft_txe_n & tx_valid;
  assign w_cnt_last = (r_cnt == CNT_W'(MAX_BURST - 1));

  // Next state plus the input-dependent strobes (rx_ce, ft_wr_n, tx_pop).
  always_comb begin
    w_next   = r_state;
    w_rx_ce  = 1'b0;
    w_tx_pop = 1'b0;
    w_wr_n   = 1'b1;
    w_beat   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rx_req && (!w_tx_req || r_last_tx)) w_next = S_RX_OE;
        else if (w_tx_req)                        w_next = S_TX_BURST;
      end
      S_RX_OE: w_next = S_RX_BURST;
      S_RX_BURST: begin
        w_rx_ce = ~rx_afull;
        w_beat  = ~ft_rxf_n & w_rx_ce;
        if (ft_rxf_n || rx_afull || (w_beat && w_cnt_last)) w_next = S_TURN;
      end
      S_TX_BURST: begin
        w_wr_n   = ~tx_valid;
        w_tx_pop = tx_valid & ~ft_txe_n;
        w_beat   = w_tx_pop;
        if (ft_txe_n || !tx_valid || (w_beat && w_cnt_last)) w_next = S_TURN;
      end
      S_TURN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, fairness and burst counter; state-only outputs are flopped from the next state.
  always_ff @(posedge ft_clk) begin
    if (ft_reset) begin
      r_state    <= S_IDLE;
      r_last_tx  <= 1'b1;
      r_cnt      <= '0;
      r_oe_n     <= 1'b1;
      r_rd_n     <= 1'b1;
      r_data_oe  <= 1'b0;
      r_grant_rx <= 1'b0;
      r_grant_tx <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) begin
        r_cnt <= '0;
        if (w_next == S_RX_OE)    r_last_tx <= 1'b0;
        if (w_next == S_TX_BURST) r_last_tx <= 1'b1;
      end else if (w_beat) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_oe_n     <= ~((w_next == S_RX_OE) || (w_next == S_RX_BURST));
      r_rd_n     <= ~(w_next == S_RX_BURST);
      r_data_oe  <= (w_next == S_TX_BURST);
      r_grant_rx <= (w_next == S_RX_OE) || (w_next == S_RX_BURST);
      r_grant_tx <= (w_next == S_TX_BURST);
      r_busy     <= (w_next != S_IDLE);
    end
  end

  assign ft_oe_n    = r_oe_n;
  assign ft_rd_n    = r_rd_n;
  assign ft_wr_n    = w_wr_n;
  assign ft_data_oe = r_data_oe;
  assign rx_ce      = w_rx_ce;
  assign tx_pop     = w_tx_pop;
  assign grant_rx   = r_grant_rx;
  assign grant_tx   = r_grant_tx;
  assign busy       = r_busy;

`ifdef FT601_BUS_ARB_STATS_EN
  logic [31:0] r_rx_beats;
  logic [31:0] r_tx_beats;
  logic [31:0] r_rx_bursts;
  logic [31:0] r_tx_bursts;

  // Free-running statistics; a clear beats a same-cycle increment.
  always_ff @(posedge ft_clk) begin
    if (ft_reset || stats_clear) begin
      r_rx_beats  <= '0;
      r_tx_beats  <= '0;
      r_rx_bursts <= '0;
      r_tx_bursts <= '0;
    end else begin
      if (w_beat && (r_state == S_RX_BURST)) r_rx_beats <= r_rx_beats + 32'd1;
      if (w_beat && (r_state == S_TX_BURST)) r_tx_beats <= r_tx_beats + 32'd1;
      if ((r_state == S_IDLE) && (w_next == S_RX_OE))    r_rx_bursts <= r_rx_bursts + 32'd1;
      if ((r_state == S_IDLE) && (w_next == S_TX_BURST)) r_tx_bursts <= r_tx_bursts + 32'd1;
    end
  end

  assign rx_beats  = r_rx_beats;
  assign tx_beats  = r_tx_beats;
  assign rx_bursts = r_rx_bursts;
  assign tx_bursts = r_tx_bursts;
`endif

endmodule

// File: doc/ft601_bus_arb.md
Name: ft601_bus_arb

Overview:
- Single-clock scheduler for the FT601 245-synchronous FIFO bus.
- Shares the bus between the RX direction (host→FPGA, landing in the FT601 read buffer) and the TX direction (FPGA→host, sourced from an FWFT TX FIFO).
- Drives `ft_oe_n`, `ft_rd_n`, `ft_wr_n`, the data-bus output enable and the read buffer's write qualifier `rx_ce`.
- Round-robin grant with a bounded burst length per grant, so neither direction starves the other.

Parameters:
- MAX_BURST, 256: maximum beats per grant before a forced hand-back; legal range 2..4096.
- CNT_W, 12: burst counter width; must satisfy 2^CNT_W >= MAX_BURST.

Ports:
- ft_clk  in  1  FT601 bus clock; the only clock of this block.
- ft_reset  in  1  synchronous, active-high reset.
- rx_enable  in  1  permits RX grants.
- tx_enable  in  1  permits TX grants.
- ft_rxf_n  in  1  FT601 RX data available, active low.
- ft_txe_n  in  1  FT601 TX space available, active low.
- ft_oe_n  out  1  FT601 output enable, active low.
- ft_rd_n  out  1  FT601 read strobe, active low.
- ft_wr_n  out  1  FT601 write strobe, active low.
- ft_data_oe  out  1  FPGA drives ft_data/ft_be when 1.
- rx_afull  in  1  read buffer almost-full.
- rx_ce  out  1  read buffer write qualifier.
- tx_valid  in  1  TX FIFO head word valid (FWFT).
- tx_pop  out  1  TX FIFO read enable; one pulse per beat.
- grant_rx  out  1  RX owns the bus; status only.
- grant_tx  out  1  TX owns the bus; status only.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (synchronous, active-high; honoured in any state, including mid-burst):
  - State goes to IDLE; burst count = 0; last_grant = TX, so RX wins the first tie.
  - Outputs: ft_oe_n = 1, ft_rd_n = 1, ft_wr_n = 1; ft_data_oe = 0, rx_ce = 0, tx_pop = 0, grant_rx = 0, grant_tx = 0, busy = 0.
  - A burst cut by reset is simply abandoned; no beat is lost beyond those the FT601 had already asserted.
- Request terms:
  - rx_req = rx_enable & !ft_rxf_n & !rx_afull.
  - tx_req = tx_enable & !ft_txe_n & tx_valid.
- States: IDLE, RX_OE, RX_BURST, TX_BURST, TURN.
- IDLE:
  - If rx_req & (!tx_req | last_grant == TX): go to RX_OE, set last_grant = RX.
  - Else if tx_req: go to TX_BURST, set last_grant = TX.
  - Else stay. Burst count is cleared on entry to either burst state.
- RX_OE: exactly one cycle.
  - ft_oe_n = 0, ft_rd_n = 1, grant_rx = 1.
  - Then go to RX_BURST unconditionally (bus turnaround).
- RX_BURST:
  - ft_oe_n = 0, ft_rd_n = 0, grant_rx = 1, rx_ce = !rx_afull.
  - Beat = !ft_rxf_n & rx_ce; the count increments per beat.
  - Go to TURN when any of: ft_rxf_n = 1, rx_afull = 1, or a beat occurs with count == MAX_BURST-1.
  - The last beat is written in the exit cycle.
- TX_BURST:
  - ft_data_oe = 1, grant_tx = 1.
  - ft_wr_n = !tx_valid and tx_pop = tx_valid & !ft_txe_n; both combinational from the registered state and inputs.
  - Beat = tx_pop; the count increments per beat.
  - Go to TURN when any of: ft_txe_n = 1, tx_valid = 0, or a beat with count == MAX_BURST-1.
- TURN: exactly one cycle.
  - All strobes deasserted, ft_data_oe = 0, rx_ce = 0.
  - Then go to IDLE.
- Latency:
  - IDLE→first RX beat: 2 cycles.
  - IDLE→first TX beat: 1 cycle.
  - Minimum gap between grants: TURN + IDLE = 2 cycles.
- Invariants (never violated):
  - ft_data_oe = 1 and ft_oe_n = 0 are never both true.
  - ft_rd_n = 0 and ft_wr_n = 0 are never both true.
  - tx_pop is never asserted while tx_valid = 0.
- Disable while granted: deasserting rx_enable/tx_enable mid-burst does not abort the burst; it only blocks the next grant.
- rx_afull rises mid-burst: rx_ce drops in the same cycle and no beat is written; exit to TURN follows.
- Clocking note: the read buffer samples on the inverted ft_clk. All outputs here change only on the rising edge, giving it half a cycle of setup.

Optional Feature:
- Macro: FT601_BUS_ARB_STATS_EN.
- When defined, adds these ports:
  - stats_clear, in, 1.
  - rx_beats, out, 32.
  - tx_beats, out, 32.
  - rx_bursts, out, 32.
  - tx_bursts, out, 32.
- Counter behaviour:
  - The beat counters increment per beat; the burst counters increment on entry to RX_OE / TX_BURST.
  - All wrap modulo 2^32.
  - Cleared by ft_reset or stats_clear; clear wins over a same-cycle increment.
- When undefined: the ports and counters do not exist, and arbitration behaviour is identical.

Test Plan:
- Reset, then rxf_n = 0 with rx_afull = 0 held for 10 cycles, rx_enable = 1 → ft_oe_n low at cycle 1, ft_rd_n and rx_ce low/high from cycle 2, 8 beats counted, TURN once rxf_n rises.
- MAX_BURST = 4, rxf_n = 0 and txe_n = 0 continuous, tx_valid = 1 → grants alternate RX(4 beats), TURN, IDLE, TX(4 pops), TURN, IDLE, RX, ...; ft_rd_n and ft_wr_n never overlap.
- RX burst with rx_afull asserted at beat 3 → rx_ce = 0 in that cycle, exactly 3 beats written, TURN next.
- TX burst with tx_valid dropping after 5 pops → ft_wr_n high in the same cycle, tx_pop count = 5, ft_data_oe low one cycle later.
- ft_reset pulsed mid TX burst → next edge: ft_data_oe = 0, all strobes high, busy = 0, IDLE; the next tie goes to RX.
- With FT601_BUS_ARB_STATS_EN: two RX bursts of 3 beats, one TX burst of 7 beats → rx_beats = 6, rx_bursts = 2, tx_beats = 7, tx_bursts = 1. stats_clear zeroes all four counters.
